ftdnn_sched: RTL and testbench
==============================

FTDNN_SCHED -- requirements
Module: ftdnn_sched

Interface
REQ-001 SHALL have parameter HW_D3, default 4, number of sblk rows reporting status.
REQ-002 SHALL have parameter TEMP_PARAM_LEN, default 32, width of the temporal parameter word.
REQ-003 SHALL have parameter ACT_W, default 64, activation word width (2x ACTBUF_DATA_LEN).
REQ-004 SHALL have parameter CNT_W, default 16, width of the activation word count.
REQ-005 SHALL have parameter DRAIN_MIN, default 4, minimum DRAIN dwell in cycles (1 or more).
REQ-006 SHALL have port clk_h, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-008 SHALL have ports desc_valid (input, 1), desc_ready (output, 1), desc_param (input, TEMP_PARAM_LEN), desc_len (input, CNT_W); together these form the layer descriptor handshake.
REQ-009 SHALL have ports act_in_data (input, ACT_W), act_in_valid (input, 1), act_in_ready (output, 1); this is the upstream activation stream.
REQ-010 SHALL have ports temp_param (output, TEMP_PARAM_LEN) and temp_param_en (output, 1); these configure the array.
REQ-011 SHALL have ports actbuf_wr_data (output, ACT_W), actbuf_wr_vld (output, 1), actbuf_wr_req (input, 1); these drive the activation buffer write.
REQ-012 SHALL have port sblk_status, input, HW_D3, one bit per row, high = row idle/complete.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1); done is a one-cycle pulse.

Function
REQ-014 SHALL implement FSM states IDLE, CFG, STREAM, DRAIN, DONE.
REQ-015 IDLE behaviour: desc_ready=1; desc_valid&desc_ready captures desc_param/desc_len into registers and moves to CFG next cycle.
REQ-016 CFG behaviour: temp_param_en=1 for exactly one cycle, with temp_param = captured param; next state is DRAIN if len==0, else STREAM.
REQ-017 temp_param SHALL hold its last configured value in all states until the next CFG.
REQ-018 STREAM behaviour:
  - act_in_ready=actbuf_wr_req.
  - actbuf_wr_vld=act_in_valid&actbuf_wr_req.
  - actbuf_wr_data=act_in_data (zero-latency pass-through).
  - A transfer is act_in_valid&act_in_ready.
REQ-019 STREAM counting: an internal counter SHALL increment per transfer; the transfer with count==len-1 moves the FSM to DRAIN and clears the count.
REQ-020 Outside STREAM: act_in_ready=0, actbuf_wr_vld=0, actbuf_wr_data=0.
REQ-021 actbuf_wr_req low in STREAM SHALL stall with no transfer and no count change; act_in_valid low likewise.
REQ-022 DRAIN behaviour: stay at least DRAIN_MIN cycles, then exit to DONE on the first cycle sblk_status is all ones.
REQ-023 DONE behaviour: done=1 for one cycle, then IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 desc_valid outside IDLE SHALL be ignored (desc_ready=0); a descriptor accepted in IDLE is never lost.

Reset
REQ-026 Reset values while rst_n=0: FSM=IDLE, counters=0, and temp_param, temp_param_en, actbuf_wr_vld, actbuf_wr_data, act_in_ready, desc_ready, busy, done all 0.
REQ-027 Reset asserted mid-STREAM or mid-DRAIN SHALL abandon the layer with no done pulse; desc_ready=1 on the first cycle after rst_n rises.

Configuration
REQ-028 With FTDNN_SCHED_PERF_EN defined:
  - Output perf_cycles (32) counts busy cycles of the last completed layer, latched on DONE.
  - Output perf_stall (32) counts STREAM cycles with act_in_valid=1 and actbuf_wr_req=0.
  - Both outputs reset to 0.
REQ-029 Without FTDNN_SCHED_PERF_EN, neither port nor the counter logic SHALL exist.

Structure
REQ-030 State enum, HW_D3/width defaults and FTDNN_SCHED_PERF_EN-dependent widths SHALL live in shared package ftdnn_pkg.
REQ-031 The block SHALL be single-module with no sub-module; the FSM and counters are flat.

Verification
REQ-032 Basic layer: desc len=3, param=0xA5A5A5A5, req and valid held high.
  - temp_param_en is high for 1 cycle with temp_param=0xA5A5A5A5.
  - Exactly 3 actbuf_wr_vld beats carry the source data in order.
  - After DRAIN_MIN cycles with status=4'hF, done pulses once.
REQ-033 Backpressure: len=4, actbuf_wr_req toggles 1,0,1,0; exactly 4 transfers occur, no beat while req=0, and perf_stall equals the stall cycles when enabled.
REQ-034 Zero-length: len=0 goes CFG -> DRAIN directly with no actbuf_wr_vld beat; done follows once status=4'hF.
REQ-035 Status hold: status=4'h7 for 20 cycles in DRAIN means no done; raising the status to 4'hF gives done on the next FSM step.
REQ-036 Reset mid-STREAM: rst_n low after 2 of 5 beats gives all outputs 0 and no done; a new descriptor (len=2) completes normally.
REQ-037 Busy descriptor: desc_valid held high during STREAM is not accepted until IDLE; accepted exactly once, and temp_param updates only at its CFG.

Source files
------------

// File: rtl/ftdnn_pkg.sv
// ftdnn_pkg: shared types and defaults for the FTDNN layer scheduler.
//   - sched_state_e : scheduler FSM states
//   - *_DEFAULT     : default parameter values for ftdnn_sched
//   - PERF_W        : width of the performance counters (only with FTDNN_SCHED_PERF_EN)
package ftdnn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StStream,
        StDrain,
        StDone
    } sched_state_e;

    localparam int unsigned HW_D3_DEFAULT          = 4;
    localparam int unsigned TEMP_PARAM_LEN_DEFAULT = 32;
    localparam int unsigned ACT_W_DEFAULT          = 64;
    localparam int unsigned CNT_W_DEFAULT          = 16;
    localparam int unsigned DRAIN_MIN_DEFAULT      = 4;

`ifdef FTDNN_SCHED_PERF_EN
    localparam int unsigned PERF_W = 32;
`endif

endpackage

// File: rtl/ftdnn_sched.sv
// ftdnn_sched: per-layer scheduler for the FTDNN array.
// Accepts a layer descriptor, pushes the temporal parameter to the array, streams
// desc_len activation words into the activation buffer, waits for every sblk row to
// report idle (after a minimum dwell), then pulses done.
//
// Ports
//   clk_h, rst_n                 clock, synchronous active-low reset
//   desc_valid/ready/param/len   layer descriptor handshake
//   act_in_data/valid/ready      upstream activation stream
//   temp_param, temp_param_en    array configuration (en pulses once per layer)
//   actbuf_wr_data/vld, _req     activation buffer write (req = buffer can accept)
//   sblk_status                  one bit per row, 1 = row idle/complete
//   busy, done                   busy outside IDLE; done is a one-cycle pulse
//   perf_cycles, perf_stall      only when FTDNN_SCHED_PERF_EN is defined
//
// Optional feature macro: FTDNN_SCHED_PERF_EN (performance counters).
module ftdnn_sched
    import ftdnn_pkg::*;
#(
    parameter int unsigned HW_D3          = HW_D3_DEFAULT,
    parameter int unsigned TEMP_PARAM_LEN = TEMP_PARAM_LEN_DEFAULT,
    parameter int unsigned ACT_W          = ACT_W_DEFAULT,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT,
    parameter int unsigned DRAIN_MIN      = DRAIN_MIN_DEFAULT
) (
    input  logic                      clk_h,
    input  logic                      rst_n,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [TEMP_PARAM_LEN-1:0] desc_param,
    input  logic [CNT_W-1:0]          desc_len,
    input  logic [ACT_W-1:0]          act_in_data,
    input  logic                      act_in_valid,
    output logic                      act_in_ready,
    output logic [TEMP_PARAM_LEN-1:0] temp_param,
    output logic                      temp_param_en,
    output logic [ACT_W-1:0]          actbuf_wr_data,
    output logic                      actbuf_wr_vld,
    input  logic                      actbuf_wr_req,
    input  logic [HW_D3-1:0]          sblk_status,
`ifdef FTDNN_SCHED_PERF_EN
    output logic [PERF_W-1:0]         perf_cycles,
    output logic [PERF_W-1:0]         perf_stall,
`endif
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned DRAIN_W = $clog2(DRAIN_MIN) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MIN - 1);

    sched_state_e              state_q;
    logic [CNT_W-1:0]          len_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DRAIN_W-1:0]        drain_q;
    logic [TEMP_PARAM_LEN-1:0] tparam_q;
    logic                      xfer;

    assign xfer = act_in_valid && act_in_ready;

    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            len_q    <= '0;
            cnt_q    <= '0;
            drain_q  <= '0;
            tparam_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (desc_valid) begin
                        // Loaded on entry to CFG so the array sees the new value
                        // together with temp_param_en, and holds it until the next CFG.
                        tparam_q <= desc_param;
                        len_q    <= desc_len;
                        cnt_q    <= '0;
                        state_q  <= StCfg;
                    end
                end
                StCfg: begin
                    drain_q <= '0;
                    state_q <= (len_q == '0) ? StDrain : StStream;
                end
                StStream: begin
                    if (xfer) begin
                        if (cnt_q == len_q - CNT_W'(1)) begin
                            cnt_q   <= '0;
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StDrain: begin
                    // drain_q saturates at DRAIN_LAST: that is the first cycle
                    // on which the dwell is satisfied.
                    if ((drain_q == DRAIN_LAST) && (&sblk_status)) begin
                        state_q <= StDone;
                    end else if (drain_q != DRAIN_LAST) begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode the registered state; gating with rst_n forces them low for the
    // whole reset window, including the cycle before the first reset edge.
    always_comb begin
        desc_ready     = rst_n && (state_q == StIdle);
        temp_param_en  = rst_n && (state_q == StCfg);
        temp_param     = rst_n ? tparam_q : '0;
        act_in_ready   = rst_n && (state_q == StStream) && actbuf_wr_req;
        actbuf_wr_vld  = act_in_ready && act_in_valid;
        actbuf_wr_data = (rst_n && (state_q == StStream)) ? act_in_data : '0;
        busy           = rst_n && (state_q != StIdle);
        done           = rst_n && (state_q == StDone);
    end

`ifdef FTDNN_SCHED_PERF_EN
    logic [PERF_W-1:0] busy_cnt_q;
    logic [PERF_W-1:0] perf_cycles_q;
    logic [PERF_W-1:0] perf_stall_q;

    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            busy_cnt_q    <= '0;
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            busy_cnt_q <= (state_q == StIdle) ? '0 : busy_cnt_q + PERF_W'(1);
            // The DONE cycle itself is busy, hence the +1.
            if (state_q == StDone) begin
                perf_cycles_q <= busy_cnt_q + PERF_W'(1);
            end
            if (state_q == StCfg) begin
                perf_stall_q <= '0;
            end else if ((state_q == StStream) && act_in_valid && !actbuf_wr_req) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_ftdnn_sched.sv
module tb_ftdnn_sched;

    localparam int DRAIN_MIN = 4;

    logic        clk_h = 1'b0;
    logic        rst_n;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_param;
    logic [15:0] desc_len;
    logic [63:0] act_in_data;
    logic        act_in_valid;
    logic        act_in_ready;
    logic [31:0] temp_param;
    logic        temp_param_en;
    logic [63:0] actbuf_wr_data;
    logic        actbuf_wr_vld;
    logic        actbuf_wr_req;
    logic [3:0]  sblk_status;
    logic        busy;
    logic        done;
`ifdef FTDNN_SCHED_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_h = ~clk_h;

    ftdnn_sched #(
        .HW_D3(4), .TEMP_PARAM_LEN(32), .ACT_W(64), .CNT_W(16), .DRAIN_MIN(DRAIN_MIN)
    ) dut (
        .clk_h          (clk_h),
        .rst_n          (rst_n),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_param     (desc_param),
        .desc_len       (desc_len),
        .act_in_data    (act_in_data),
        .act_in_valid   (act_in_valid),
        .act_in_ready   (act_in_ready),
        .temp_param     (temp_param),
        .temp_param_en  (temp_param_en),
        .actbuf_wr_data (actbuf_wr_data),
        .actbuf_wr_vld  (actbuf_wr_vld),
        .actbuf_wr_req  (actbuf_wr_req),
        .sblk_status    (sblk_status),
`ifdef FTDNN_SCHED_PERF_EN
        .perf_cycles    (perf_cycles),
        .perf_stall     (perf_stall),
`endif
        .busy           (busy),
        .done           (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    `define CHK(t, o, e) chk(t, 64'(o), 64'(e))

    task automatic chk_all_zero(input string tag);
        `CHK({tag, "_busy"}, busy, 0);
        `CHK({tag, "_done"}, done, 0);
        `CHK({tag, "_desc_ready"}, desc_ready, 0);
        `CHK({tag, "_act_in_ready"}, act_in_ready, 0);
        `CHK({tag, "_wr_vld"}, actbuf_wr_vld, 0);
        `CHK({tag, "_wr_data"}, actbuf_wr_data, 0);
        `CHK({tag, "_tparam"}, temp_param, 0);
        `CHK({tag, "_tparam_en"}, temp_param_en, 0);
    endtask

    // One layer from the descriptor in IDLE to DONE (and the following IDLE unless the
    // next descriptor is already pending). Expectations come from the layer rules:
    // beats = source words offered while valid&req, until len transfers; DRAIN ends on
    // the first cycle at or past the dwell with all rows idle.
    //   rpct < 0      : req toggles 1,0,1,0...
    //   hold_val >= 0 : status value before ones_from (else random, never all ones)
    //   pend          : keep the next descriptor asserted from CFG onwards
    task automatic run_layer(input logic [31:0] param, input int len, input int vpct,
                             input int rpct, input int ones_from, input int hold_val,
                             input bit pend, input logic [31:0] nparam, input int nlen);
        logic [63:0] exp_q[$];
        logic [63:0] got_q[$];
        int          xfers = 0;
        int          k = 0;
        int          d = 0;
        int          stalls = 0;
        int          busy_cyc = 0;
        bit          v, r, fin;
        logic [3:0]  st;
        logic [63:0] dat;

        // IDLE: descriptor offered and accepted
        @(negedge clk_h);
        desc_valid = 1'b1; desc_param = param; desc_len = 16'(len);
        act_in_valid = 1'b1; act_in_data = {$urandom, $urandom}; actbuf_wr_req = 1'b1;
        sblk_status = 4'hF;
        #1;
        `CHK("idle_desc_ready", desc_ready, 1);
        `CHK("idle_busy", busy, 0);
        `CHK("idle_wr_vld", actbuf_wr_vld, 0);

        // CFG
        @(negedge clk_h);
        desc_valid = pend; desc_param = nparam; desc_len = 16'(nlen);
        #1;
        `CHK("cfg_en", temp_param_en, 1);
        `CHK("cfg_param", temp_param, param);
        `CHK("cfg_busy", busy, 1);
        `CHK("cfg_desc_ready", desc_ready, 0);
        `CHK("cfg_act_in_ready", act_in_ready, 0);
        `CHK("cfg_wr_data", actbuf_wr_data, 0);
        busy_cyc = 1;

        // STREAM
        while (xfers < len) begin
            if (k >= 2000) begin
                `CHK("stream_timeout", 0, 1);
                return;
            end
            @(negedge clk_h);
            v = ($urandom_range(0, 99) < vpct);
            r = (rpct < 0) ? (k % 2 == 0) : ($urandom_range(0, 99) < rpct);
            dat = {$urandom, $urandom};
            act_in_valid = v; actbuf_wr_req = r; act_in_data = dat;
            #1;
            `CHK("stream_act_in_ready", act_in_ready, r);
            `CHK("stream_wr_vld", actbuf_wr_vld, v && r);
            `CHK("stream_wr_data", actbuf_wr_data, dat);
            `CHK("stream_tparam_en", temp_param_en, 0);
            `CHK("stream_tparam", temp_param, param);
            `CHK("stream_desc_ready", desc_ready, 0);
            `CHK("stream_done", done, 0);
            n_vec++;
            if (actbuf_wr_data !== dat) begin
                n_err++;
                $error("FAIL stream_pass: observed %h expected %h", actbuf_wr_data, dat);
            end
            n_vec++;
            if (actbuf_wr_vld !== (v && r)) begin
                n_err++;
                $error("FAIL stream_vld: observed %b expected %b", actbuf_wr_vld, v && r);
            end
            if (v && r) begin
                exp_q.push_back(dat);
                xfers++;
            end
            if (actbuf_wr_vld) got_q.push_back(actbuf_wr_data);
            if (v && !r) stalls++;
            k++;
            busy_cyc++;
        end
        `CHK("beat_count", got_q.size(), len);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            `CHK("beat_order", got_q[i], exp_q[i]);
        end

        // DRAIN
        fin = 1'b0;
        while (!fin) begin
            if (d > ones_from + DRAIN_MIN + 4) begin
                `CHK("drain_timeout", 0, 1);
                return;
            end
            @(negedge clk_h);
            if (d >= ones_from) st = 4'hF;
            else if (hold_val >= 0) st = hold_val[3:0];
            else st = 4'($urandom_range(0, 14));
            sblk_status = st;
            act_in_valid = 1'b1; actbuf_wr_req = 1'b1; act_in_data = {$urandom, $urandom};
            #1;
            `CHK("drain_wr_vld", actbuf_wr_vld, 0);
            `CHK("drain_act_in_ready", act_in_ready, 0);
            `CHK("drain_wr_data", actbuf_wr_data, 0);
            `CHK("drain_done", done, 0);
            `CHK("drain_busy", busy, 1);
            `CHK("drain_desc_ready", desc_ready, 0);
            `CHK("drain_tparam", temp_param, param);
            fin = (d >= DRAIN_MIN - 1) && (st == 4'hF);
            d++;
            busy_cyc++;
        end

        // DONE
        @(negedge clk_h);
        act_in_valid = 1'b0;
        #1;
        `CHK("done_pulse", done, 1);
        `CHK("done_busy", busy, 1);
        `CHK("done_desc_ready", desc_ready, 0);
        `CHK("done_tparam", temp_param, param);
        busy_cyc++;
        if (pend) return;

        // IDLE again
        @(negedge clk_h);
        desc_valid = 1'b0;
        #1;
        `CHK("post_done", done, 0);
        `CHK("post_busy", busy, 0);
        `CHK("post_desc_ready", desc_ready, 1);
        `CHK("post_tparam_hold", temp_param, param);
`ifdef FTDNN_SCHED_PERF_EN
        `CHK("perf_cycles", perf_cycles, busy_cyc);
        `CHK("perf_stall", perf_stall, stalls);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        desc_valid = 1'b0; desc_param = 32'h0; desc_len = 16'h0;
        act_in_data = 64'hDEAD_BEEF_0000_0001; act_in_valid = 1'b1;
        actbuf_wr_req = 1'b1; sblk_status = 4'hF;

        // Reset state
        @(negedge clk_h);
        @(negedge clk_h);
        #1;
        chk_all_zero("reset");
        @(negedge clk_h);
        rst_n = 1'b1; act_in_valid = 1'b0;
        #1;
        `CHK("reset_release_ready", desc_ready, 1);
        n_vec++;
        if (desc_ready !== 1'b1) begin
            n_err++;
            $error("FAIL reset_release_direct: desc_ready %b", desc_ready);
        end

        // Basic layer
        run_layer(32'hA5A5_A5A5, 3, 100, 100, 0, -1, 1'b0, 32'h0, 0);
        // Backpressure: req 1,0,1,0
        run_layer(32'h0BAD_F00D, 4, 100, -1, 0, -1, 1'b0, 32'h0, 0);
        // Zero length
        run_layer(32'h1357_9BDF, 0, 100, 100, 0, -1, 1'b0, 32'h0, 0);
        // Status held at 7 for 20 DRAIN cycles
        run_layer(32'h2468_ACE0, 2, 100, 100, 20, 7, 1'b0, 32'h0, 0);

        // Reset mid-STREAM after 2 of 5 beats
        @(negedge clk_h);
        desc_valid = 1'b1; desc_param = 32'hCAFE_0005; desc_len = 16'd5;
        #1;
        `CHK("rst_mid_accept", desc_ready, 1);
        @(negedge clk_h);
        desc_valid = 1'b0; act_in_valid = 1'b1; actbuf_wr_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_h);
            act_in_data = {$urandom, $urandom};
            #1;
            `CHK("rst_mid_beat", actbuf_wr_vld, 1);
            n_vec++;
            if (actbuf_wr_vld !== 1'b1) begin
                n_err++;
                $error("FAIL rst_mid_beat_direct: actbuf_wr_vld %b", actbuf_wr_vld);
            end
        end
        @(negedge clk_h);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid_a");
        @(negedge clk_h);
        #1;
        chk_all_zero("rst_mid_b");
        @(negedge clk_h);
        rst_n = 1'b1; act_in_valid = 1'b0;
        #1;
        `CHK("rst_mid_ready", desc_ready, 1);
        `CHK("rst_mid_no_done", done, 0);
        `CHK("rst_mid_busy", busy, 0);
        run_layer(32'h0000_0002, 2, 100, 100, 0, -1, 1'b0, 32'h0, 0);

        // Descriptor held during a busy layer: taken once, in the following IDLE
        run_layer(32'h1111_2222, 3, 100, 100, 0, -1, 1'b1, 32'h3333_4444, 2);
        run_layer(32'h3333_4444, 2, 100, 100, 0, -1, 1'b0, 32'h0, 0);

        // Randomised layers
        for (int n = 0; n < 8; n++) begin
            run_layer({$urandom}, int'($urandom_range(0, 8)), int'($urandom_range(30, 100)),
                      int'($urandom_range(30, 100)), int'($urandom_range(0, 8)), -1,
                      1'b0, 32'h0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
